// File: rtl/dot_job_arbiter_if.sv
// Handshake bundle between dot_job_arbiter, its requesters, the dot-product engine and the response sink.
// master: the arbiter's view; slave: the environment (requesters, engine, response consumer).
interface dot_job_arbiter_if #(
   parameter int NUM_REQ  = 4,
   parameter int ID_W     = 2,
   parameter int RESULT_W = 32,
   parameter int LAT_W    = 16
);
   logic [NUM_REQ-1:0]  req_valid;
   logic [NUM_REQ-1:0]  req_ready;
   logic [ID_W-1:0]     eng_sel;
   logic                eng_start;
   logic                eng_done;
   logic [RESULT_W-1:0] eng_result;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [ID_W-1:0]     rsp_id;
   logic [RESULT_W-1:0] rsp_data;
   logic                rsp_err;
   logic [LAT_W-1:0]    lat_cycles;
   logic                busy;
   logic                err_spurious;

   modport master (
      input  req_valid, eng_done, eng_result, rsp_ready,
      output req_ready, eng_sel, eng_start, rsp_valid, rsp_id, rsp_data, rsp_err,
             lat_cycles, busy, err_spurious
   );

   modport slave (
      output req_valid, eng_done, eng_result, rsp_ready,
      input  req_ready, eng_sel, eng_start, rsp_valid, rsp_id, rsp_data, rsp_err,
             lat_cycles, busy, err_spurious
   );
endinterface

// File: rtl/dot_job_arbiter.sv
// Round-robin arbiter sharing one dot-product engine between NUM_REQ requesters, one job at a time.
// Define DOT_JOB_ARB_TIMEOUT_EN to add a BUSY watchdog that aborts a job after TIMEOUT_CYCLES.
module dot_job_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int RESULT_W       = 32,
   parameter int LAT_W          = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input logic                clk,
   input logic                rst_n,
   dot_job_arbiter_if.master  bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

   state_t           state;
   logic [ID_W-1:0]  last_grant;
   logic [ID_W-1:0]  gnt_id;
   logic [LAT_W-1:0] lat_cnt;
   logic [LAT_W-1:0] lat_next;
   logic             pick_any;
   logic [ID_W-1:0]  pick_id;
   logic [ID_W-1:0]  cand;

   // The granted id doubles as the engine operand select, so it cannot move mid-job.
   assign bus.eng_sel = gnt_id;
   assign lat_next    = (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;

   // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
   always_comb begin
      pick_any = 1'b0;
      pick_id  = '0;
      cand     = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
         if (!pick_any && bus.req_valid[cand]) begin
            pick_any = 1'b1;
            pick_id  = cand;
         end
      end
   end

`ifdef DOT_JOB_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;
   logic            wd_expire;
   assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         last_grant       <= ID_W'(NUM_REQ - 1);
         gnt_id           <= '0;
         lat_cnt          <= '0;
         bus.req_ready    <= '0;
         bus.eng_start    <= 1'b0;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_id       <= '0;
         bus.rsp_data     <= '0;
         bus.rsp_err      <= 1'b0;
         bus.lat_cycles   <= '0;
         bus.busy         <= 1'b0;
         bus.err_spurious <= 1'b0;
`ifdef DOT_JOB_ARB_TIMEOUT_EN
         wd_cnt           <= '0;
`endif
      end else begin
         if (bus.eng_done && state != BUSY) bus.err_spurious <= 1'b1;

         case (state)
            IDLE: begin
               if (pick_any) begin
                  gnt_id        <= pick_id;
                  bus.req_ready <= NUM_REQ'(1) << pick_id;
                  bus.eng_start <= 1'b1;
                  bus.busy      <= 1'b1;
                  state         <= ISSUE;
               end
            end

            ISSUE: begin
               bus.req_ready <= '0;
               bus.eng_start <= 1'b0;
               lat_cnt       <= '0;
`ifdef DOT_JOB_ARB_TIMEOUT_EN
               wd_cnt        <= '0;
`endif
               state         <= BUSY;
            end

            BUSY: begin
               if (bus.eng_done) begin
                  bus.rsp_data   <= bus.eng_result;
                  bus.rsp_id     <= gnt_id;
                  bus.rsp_err    <= 1'b0;
                  bus.lat_cycles <= lat_next;
                  bus.rsp_valid  <= 1'b1;
                  state          <= RESP;
               end
`ifdef DOT_JOB_ARB_TIMEOUT_EN
               else if (wd_expire) begin
                  bus.rsp_data   <= '0;
                  bus.rsp_id     <= gnt_id;
                  bus.rsp_err    <= 1'b1;
                  bus.lat_cycles <= '1;
                  bus.rsp_valid  <= 1'b1;
                  state          <= RESP;
               end
`endif
               else begin
                  lat_cnt <= lat_next;
`ifdef DOT_JOB_ARB_TIMEOUT_EN
                  wd_cnt  <= wd_cnt + 1'b1;
`endif
               end
            end

            RESP: begin
               if (bus.rsp_valid && bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  bus.busy      <= 1'b0;
                  last_grant    <= gnt_id;
                  state         <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/dot_job_arbiter.md
Name: dot_job_arbiter

Overview:
- Shares one dot-product engine between NUM_REQ requesters, round-robin.
- Per job, the block:
  - accepts one requester's request;
  - drives the engine's operand-select index;
  - pulses the engine start;
  - waits for the engine done pulse;
  - returns the 32-bit result on a shared response channel tagged with the requester id.
- Sits between the host/requester ports and the parallel dot-product engine; upstream operand muxing uses eng_sel.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- ID_W, 2: width of requester id; must be >= clog2(NUM_REQ).
- RESULT_W, 32: engine result / response data width.
- LAT_W, 16: width of the per-job latency counter.
- TIMEOUT_CYCLES, 4096: watchdog limit in BUSY (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester job request; held until accepted.
- req_ready  out  NUM_REQ  one-hot acceptance, 1 cycle.
- eng_sel  out  ID_W  requester whose vectors feed the engine.
- eng_start  out  1  engine start pulse, 1 cycle.
- eng_done  in  1  engine completion pulse.
- eng_result  in  RESULT_W  engine result, valid with eng_done.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  requester the response belongs to.
- rsp_data  out  RESULT_W  dot-product result.
- rsp_err  out  1  job aborted (timeout).
- lat_cycles  out  LAT_W  eng_start-to-eng_done cycles of the last job, saturating.
- busy  out  1  high whenever state != IDLE.
- err_spurious  out  1  sticky: eng_done seen outside BUSY.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first.
  - All outputs 0: req_ready, eng_sel, eng_start, rsp_valid, rsp_id, rsp_data, rsp_err, lat_cycles, busy, err_spurious.
  - Reset mid-job abandons the job with no response; the engine is not notified.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
  - Register gnt_id, set eng_sel=gnt_id, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - req_ready[gnt_id]=1, eng_start=1, both for exactly this cycle; lat counter cleared; go to BUSY.
  - Requesters must hold req_valid until req_ready; dropping it earlier is a protocol violation and the job still runs.
- BUSY:
  - lat counter increments each cycle, saturating at all-ones.
  - On eng_done: rsp_data<=eng_result, rsp_id<=gnt_id, rsp_err<=0, lat_cycles<=counter+1 (saturating), rsp_valid<=1; go to RESP.
  - eng_done in the ISSUE cycle is treated as spurious; the engine needs at least 1 cycle.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err stay stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, last_grant<=gnt_id, go to IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- eng_sel holds gnt_id from IDLE exit until the next grant; it never changes while busy.
- eng_done in IDLE, ISSUE or RESP: ignored for data; sets err_spurious, which clears only on reset.
- Minimum per-job period: engine latency + 3 cycles (IDLE→ISSUE→BUSY…→RESP→IDLE) with rsp_ready tied high.
- Requests newly asserted in non-IDLE states wait; there is no queueing beyond the req_valid hold.

Optional Feature:
- Macro: DOT_JOB_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts BUSY cycles.
  - When it reaches TIMEOUT_CYCLES without eng_done, go to RESP with rsp_data=0, rsp_err=1, lat_cycles=all-ones saturating.
  - A later eng_done is spurious.
- Undefined: no watchdog logic; rsp_err is constant 0; BUSY waits indefinitely.

Test Plan:
- Single requester: req_valid=4'b0100, engine returns 32'h0000_1234 after 10 cycles → req_ready[2] and eng_start pulse in the same cycle; rsp_id=2, rsp_data=32'h1234, lat_cycles=10, rsp_err=0.
- All four requesting continuously, rsp_ready=1 → grant order 0,1,2,3,0; eng_sel matches each rsp_id.
- Backpressure: rsp_ready low for 20 cycles during RESP → rsp fields stable, no new eng_start, busy=1 throughout; then one transfer.
- eng_done pulsed in IDLE → err_spurious=1 and stays 1; no rsp_valid.
- Reset asserted in BUSY → all outputs 0 immediately; after release with req_valid=4'b1000 → requester 3 granted next, since the pointer resets to favour 0 and only 3 is requesting.
- With DOT_JOB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, engine silent → rsp_valid after 16 BUSY cycles, rsp_err=1, rsp_data=0; a late eng_done sets err_spurious.
